seg_bcd_conv: RTL and testbench
===============================

# seg_bcd_conv

Sequential binary-to-BCD converter that feeds the 4-digit multiplexed 7-segment scanner. It accepts a binary value and decimal-point mask on a start strobe and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents four packed BCD digits and a dot mask on registered outputs that stay stable between conversions. Its `number`/`dot` outputs connect directly to the scanner's `number`/`dot` inputs.

## Interface
- `WIDTH`, 14: binary input width, legal range 4..14; 14 bits covers 0..16383.
- `clk` in 1: single clock; all state on rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `bin` in WIDTH: unsigned binary value, sampled on accepted `start`.
- `dp_in` in 4: decimal-point mask, sampled with `bin`; bit 3 = leftmost digit.
- `start` in 1: conversion request; accepted only when `busy`=0.
- `number` out 16: packed BCD, [15:12] thousands … [3:0] units.
- `dot` out 4: dot mask for the scanner.
- `ovf` out 1: last converted value exceeded 9999.
- `busy` out 1: conversion in progress.
- `done` out 1: one-cycle pulse when `number`/`dot`/`ovf` update.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if `start`=1, capture `bin` into shift register `sr` (WIDTH bits) and `dp_in` into `dp_q`. Clear 20-bit scratch `bcd` (5 digits). Load bit counter with WIDTH. Go to SHIFT.
- SHIFT, each cycle:
  - Every `bcd` nibble ≥5 gets +3; all five digits are adjusted in parallel.
  - Then `{bcd, sr}` shifts left by 1.
  - Counter decrements; on the cycle the counter reaches 0, go to DONE.
- DONE, one cycle:
  - Register `number`, `dot`, `ovf` from `bcd` and `dp_q` per Configuration.
  - Assert `done`; return to IDLE.
- `ovf` = (`bcd`[19:16] != 0) OR (`bcd`[15:0] > 16'h9999). The second term is unreachable but must be kept for WIDTH safety.
- `start` while `busy`=1: ignored, not queued; the in-flight conversion is unaffected.
- `bin`/`dp_in` changes after acceptance: no effect on the in-flight result.
- Outputs hold the last result indefinitely; the scanner may sample them at any time.

## Timing
- Reset values: `number`=16'h0000, `dot`=4'b0000, `ovf`=0, `busy`=0, `done`=0, state IDLE. All internal registers cleared.
- `start` sampled high in IDLE at edge N:
  - `busy`=1 from edge N through edge N+WIDTH (SHIFT for WIDTH cycles).
  - At edge N+WIDTH+1, `number`/`dot`/`ovf` update, `done`=1 and `busy`=0 for one cycle.
  - Total latency is WIDTH+1 clocks; 15 at default.
- `start` high in the `done` cycle is accepted (state is IDLE there); back-to-back throughput is one result per WIDTH+1 clocks.
- `busy` is registered; it equals (state != IDLE) with DONE counted as busy=0.
- Reset mid-conversion: immediately aborts; all outputs return to reset values; the partial result is discarded.

## Configuration
- `SEG_BCD_SAT_EN` defined, on overflow:
  - `number`=16'h9999 and `dot`=4'b1111, regardless of `dp_q`.
  - `ovf`=1.
- `SEG_BCD_SAT_EN` undefined, on overflow:
  - `number`=`bcd`[15:0], i.e. the value modulo 10000.
  - `dot`=`dp_q`; `ovf`=1.
- Non-overflow results are identical in both builds: `number`=`bcd`[15:0], `dot`=`dp_q`, `ovf`=0.

## Test plan
- Reset then idle: `number`=16'h0000, `dot`=0, `busy`=0, `done` never pulses without `start`.
- `bin`=1234, `dp_in`=4'b0100, pulse `start`:
  - `busy` high 14 cycles.
  - `done` pulses at cycle 15.
  - `number`=16'h1234, `dot`=4'b0100, `ovf`=0.
- Boundaries:
  - `bin`=0 → 16'h0000.
  - `bin`=9999 → 16'h9999, `ovf`=0.
  - `bin`=10 → 16'h0010 (exercises the +3 carry).
- `bin`=12345, `dp_in`=4'b0001:
  - With SEG_BCD_SAT_EN: 16'h9999, `dot`=4'b1111, `ovf`=1.
  - Without: 16'h2345, `dot`=4'b0001, `ovf`=1.
- `start` at cycle 0 (`bin`=42), then `start` again at cycle 5 (`bin`=77):
  - Single `done`; result 16'h0042.
  - A `start` re-issued in the `done` cycle gives 16'h0077 after 15 more cycles.
- Assert `nrst` low at cycle 7 of a conversion of 5678: outputs go to reset values; after release `number` stays 16'h0000 and no `done` pulse occurs.

Source files
------------

// File: rtl/seg_bcd_conv.sv
// seg_bcd_conv: sequential double-dabble binary-to-BCD converter feeding the 4-digit 7-segment scanner.
// Optional build macro SEG_BCD_SAT_EN: overflowed results saturate to 9999 with all dots lit.
module seg_bcd_conv #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] bin,
    input  logic [3:0]       dp_in,
    input  logic             start,
    output logic [15:0]      number,
    output logic [3:0]       dot,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [3:0]       dp_q;
    logic [19:0]      bcd;
    logic [CW-1:0]    cnt;

    logic [19:0]      bcd_adj;
    logic [19:0]      bcd_next;
    logic [WIDTH-1:0] sr_next;
    logic             ovf_c;

    // One double-dabble step: add 3 to every digit >= 5, then shift the whole chain left.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        {bcd_next, sr_next} = {bcd_adj, sr} << 1;
        // Second term cannot fire for valid BCD; kept so wider inputs stay safe.
        ovf_c = (bcd[19:16] != 4'd0) || (bcd[15:0] > 16'h9999);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= ST_IDLE;
            sr     <= '0;
            dp_q   <= 4'b0000;
            bcd    <= 20'h00000;
            cnt    <= '0;
            number <= 16'h0000;
            dot    <= 4'b0000;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr    <= bin;
                        dp_q  <= dp_in;
                        bcd   <= 20'h00000;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd <= bcd_next;
                    sr  <= sr_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef SEG_BCD_SAT_EN
                    if (ovf_c) begin
                        number <= 16'h9999;
                        dot    <= 4'b1111;
                    end else begin
                        number <= bcd[15:0];
                        dot    <= dp_q;
                    end
`else
                    number <= bcd[15:0];
                    dot    <= dp_q;
`endif
                    ovf   <= ovf_c;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bcd_conv.sv
// tb_seg_bcd_conv: scoreboard bench for seg_bcd_conv; directed vectors with hand-computed BCD results.
// Expectations for the overflow vector follow the SEG_BCD_SAT_EN build macro.
module tb_seg_bcd_conv;

    localparam int WIDTH   = 14;
    localparam int LATENCY = WIDTH + 1;

    logic             clk;
    logic             nrst;
    logic [WIDTH-1:0] bin;
    logic [3:0]       dp_in;
    logic             start;
    logic [15:0]      number;
    logic [3:0]       dot;
    logic             ovf;
    logic             busy;
    logic             done;

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dot;
        logic        ovf;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    seg_bcd_conv #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .bin    (bin),
        .dp_in  (dp_in),
        .start  (start),
        .number (number),
        .dot    (dot),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Caller sits on a negedge; start is held for exactly one rising edge, then inputs are scrambled.
    task automatic driveStart(input logic [WIDTH-1:0] value, input logic [3:0] dp);
        bin   = value;
        dp_in = dp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = WIDTH'($urandom);
        dp_in = 4'($urandom);
    endtask

    task automatic applyStimulus(input string name, input logic [WIDTH-1:0] value, input logic [3:0] dp,
                                 input logic [15:0] exp_num, input logic [3:0] exp_dot, input logic exp_ovf);
        exp_t e;
        driveStart(value, dp);
        e.num  = exp_num;
        e.dot  = exp_dot;
        e.ovf  = exp_ovf;
        e.due  = cyc + LATENCY;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL %s_timeout: done not seen within 40 cycles", name);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result, on the predicted cycle.
    always @(negedge clk) begin
        if (nrst && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL unexpected_done: got done=1 with number 0x%04h, expected no pulse", number);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_number"}, 32'(number), 32'(e.num));
                checkOutput({e.name, "_dot"}, 32'(dot), 32'(e.dot));
                checkOutput({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
                checkOutput({e.name, "_latency"}, 32'(cyc), 32'(e.due));
                checkOutput({e.name, "_busy_low"}, 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        int busy_cnt;
        int n;

        nrst  = 1'b0;
        start = 1'b0;
        bin   = '0;
        dp_in = 4'b0000;
        repeat (3) @(negedge clk);

        checkOutput("reset_number", 32'(number), 32'h0000);
        checkOutput("reset_dot", 32'(dot), 32'h0);
        checkOutput("reset_ovf", 32'(ovf), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);

        nrst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_number", 32'(number), 32'h0000);
        checkOutput("idle_busy", 32'(busy), 32'h0);

        $display("[TB] conversion of 1234");
        applyStimulus("v1234", WIDTH'(1234), 4'b0100, 16'h1234, 4'b0100, 1'b0);
        busy_cnt = 0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        checkOutput("v1234_busy_cycles", 32'(busy_cnt), 32'd14);
        @(negedge clk);

        $display("[TB] boundary values");
        applyStimulus("v0", WIDTH'(0), 4'b1000, 16'h0000, 4'b1000, 1'b0);
        waitDone("v0");
        @(negedge clk);
        applyStimulus("v9999", WIDTH'(9999), 4'b0010, 16'h9999, 4'b0010, 1'b0);
        waitDone("v9999");
        @(negedge clk);
        applyStimulus("v10", WIDTH'(10), 4'b0000, 16'h0010, 4'b0000, 1'b0);
        waitDone("v10");
        @(negedge clk);
        applyStimulus("v16383", WIDTH'(16383), 4'b0000,
`ifdef SEG_BCD_SAT_EN
                      16'h9999, 4'b1111,
`else
                      16'h6383, 4'b0000,
`endif
                      1'b1);
        waitDone("v16383");
        @(negedge clk);

        $display("[TB] overflow 12345");
        applyStimulus("v12345", WIDTH'(12345), 4'b0001,
`ifdef SEG_BCD_SAT_EN
                      16'h9999, 4'b1111,
`else
                      16'h2345, 4'b0001,
`endif
                      1'b1);
        waitDone("v12345");
        @(negedge clk);

        $display("[TB] start while busy, then start in done cycle");
        applyStimulus("v42", WIDTH'(42), 4'b0000, 16'h0042, 4'b0000, 1'b0);
        repeat (4) @(negedge clk);
        driveStart(WIDTH'(77), 4'b1010);
        waitDone("v42");
        applyStimulus("v77", WIDTH'(77), 4'b0000, 16'h0077, 4'b0000, 1'b0);
        waitDone("v77");
        @(negedge clk);

        $display("[TB] reset during conversion of 5678");
        driveStart(WIDTH'(5678), 4'b0110);
        repeat (6) @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'h1);
        nrst = 1'b0;
        #1;
        checkOutput("abort_number", 32'(number), 32'h0000);
        checkOutput("abort_dot", 32'(dot), 32'h0);
        checkOutput("abort_ovf", 32'(ovf), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (25) @(negedge clk);
        checkOutput("after_abort_number", 32'(number), 32'h0000);
        checkOutput("after_abort_busy", 32'(busy), 32'h0);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
